// File: rtl/btn_frontend_4ch_pkg.sv
// Shared types, default 100 MHz timing and a counter-width helper for the
// push-button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  // Defaults for a 100 MHz system clock.
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;    // 10 ms
  localparam int DEF_LONG_CYC     = 100_000_000;  // 1 s
  localparam int DEF_REPEAT_CYC   = 20_000_000;   // 200 ms

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_frontend_4ch_if.sv
// Button bus: raw levels in, debounced level and event strobes out.
interface btn_frontend_4ch_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pe;
  logic [N_BTN-1:0] btn_ne;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_rpt;

  // Board / stimulus side.
  modport master (
    output btn_raw,
    input  btn_level, btn_pe, btn_ne, btn_long, btn_rpt
  );

  // Front-end side.
  modport slave (
    input  btn_raw,
    output btn_level, btn_pe, btn_ne, btn_long, btn_rpt
  );
endinterface

// File: rtl/btn_frontend_4ch_channel.sv
// One button channel: two-flop synchroniser, debounce counter and an
// IDLE/PRESSED/HELD machine producing registered one-cycle strobes.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit RPT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset_p,   // active-low, asynchronous
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pe,
  output logic btn_ne,
  output logic btn_long,
  output logic btn_rpt
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYC);
  localparam int HOLD_W = cnt_width(LONG_CYC);
  localparam int RPT_W  = cnt_width(REPEAT_CYC);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYC - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  btn_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              pe_q, pe_d;
  logic              ne_q, ne_d;
  logic              long_q, long_d;
  logic              rpt_q, rpt_d;

  logic level_rise, level_fall, long_hit, rpt_hit;

  // Synchroniser and debounce: accept a change only after it has been
  // seen for DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    level_d    = level_q;
    db_cnt_d   = '0;
    level_rise = 1'b0;
    level_fall = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d    = ~level_q;
        level_rise = ~level_q;
        level_fall = level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // State register and all flops, including the registered strobes.
  always_ff @(posedge clk or negedge reset_p) begin
    if (!reset_p) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      pe_q       <= 1'b0;
      ne_q       <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      pe_q       <= pe_d;
      ne_q       <= ne_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
    end
  end

  // Next state and hold/repeat counters; a release overrides any terminal count.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    long_hit   = 1'b0;
    rpt_hit    = 1'b0;
    if (level_fall) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      rpt_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_rise) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
          end
        end
        PRESSED: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d   = HELD;
            rpt_cnt_d = '0;
            long_hit  = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (rpt_cnt_q == RPT_LAST) begin
            rpt_cnt_d = '0;
            rpt_hit   = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobe decode; channels without repeat only echo the press on btn_rpt.
  always_comb begin
    pe_d   = level_rise;
    ne_d   = level_fall;
    long_d = long_hit;
    rpt_d  = level_rise | (RPT_EN & (long_hit | rpt_hit));
  end

  assign btn_level = level_q;
  assign btn_pe    = pe_q;
  assign btn_ne    = ne_q;
  assign btn_long  = long_q;
  assign btn_rpt   = rpt_q;

endmodule

// File: rtl/btn_frontend_4ch.sv
// Four-channel push-button front end: one independent btn_channel per button.
module btn_frontend_4ch
  import btn_pkg::*;
#(
  parameter int             N_BTN        = 4,
  parameter int             DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int             LONG_CYC     = DEF_LONG_CYC,
  parameter int             REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter logic [N_BTN-1:0] RPT_MASK   = N_BTN'(4'b1100)
) (
  input  logic               clk,
  input  logic               reset_p,   // active-low, asynchronous
  btn_frontend_4ch_if.slave  bus
);

  logic [N_BTN-1:0] level_w, pe_w, ne_w, long_w, rpt_w;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .RPT_EN       (RPT_MASK[gi])
    ) u_ch (
      .clk       (clk),
      .reset_p   (reset_p),
      .btn_raw   (bus.btn_raw[gi]),
      .btn_level (level_w[gi]),
      .btn_pe    (pe_w[gi]),
      .btn_ne    (ne_w[gi]),
      .btn_long  (long_w[gi]),
      .btn_rpt   (rpt_w[gi])
    );
  end

  assign bus.btn_level = level_w;
  assign bus.btn_pe    = pe_w;
  assign bus.btn_ne    = ne_w;
  assign bus.btn_long  = long_w;
  assign bus.btn_rpt   = rpt_w;

endmodule

// File: tb/tb_btn_frontend_4ch.sv
// Bench for btn_frontend_4ch with short timing constants and a
// history-window reference model of debounce and hold timing.
module tb_btn_frontend_4ch;
  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;
  localparam logic [N-1:0] MASK = 4'b1100;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic reset_p = 1'b0;

  btn_frontend_4ch_if #(.N_BTN(N)) bus ();

  btn_frontend_4ch #(
    .N_BTN(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .RPT_MASK(MASK)
  ) dut (
    .clk(clk), .reset_p(reset_p), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state: raw samples per edge, accepted level, press edge.
  bit hist [N][HMAX];
  bit m_lvl [N];
  int m_press [N];
  logic [N-1:0] e_level = '0, e_pe = '0, e_ne = '0, e_long = '0, e_rpt = '0;

  logic [5*N-1:0] obs, expv;
  assign obs  = {bus.btn_level, bus.btn_pe, bus.btn_ne, bus.btn_long, bus.btn_rpt};
  assign expv = {e_level, e_pe, e_ne, e_long, e_rpt};

  // Advance one clock edge and compute what every channel should show after it.
  // A level change is accepted when the last D samples, seen two edges late,
  // all disagree with the current level; events follow from press age.
  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int c = 0; c < N; c++) begin
      bit tog;
      int age;
      hist[c][cyc % HMAX] = reset_p ? bus.btn_raw[c] : 1'b0;
      e_pe[c] = 1'b0; e_ne[c] = 1'b0; e_long[c] = 1'b0; e_rpt[c] = 1'b0;
      if (!reset_p) begin
        m_lvl[c] = 1'b0;
      end else begin
        tog = (cyc >= D + 1);
        for (int j = 0; j < D; j++)
          if (tog && hist[c][(cyc - 2 - j) % HMAX] == m_lvl[c]) tog = 1'b0;
        if (tog) begin
          e_pe[c]  = !m_lvl[c];
          e_ne[c]  = m_lvl[c];
          m_lvl[c] = !m_lvl[c];
          if (m_lvl[c]) m_press[c] = cyc;
        end
        if (m_lvl[c] && !e_pe[c]) begin
          age = cyc - m_press[c];
          e_long[c] = (age == L);
          e_rpt[c]  = MASK[c] && (age >= L) && ((age - L) % R == 0);
        end
        e_rpt[c] = e_rpt[c] | e_pe[c];
      end
      e_level[c] = m_lvl[c];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.btn_raw = '0;
    reset_p = 1'b0;
    repeat (3) begin
      tick();
      n_cmp++;
      if (obs !== '0) begin
        n_bad++; $display("FAIL reset_state cyc=%0d got=%b exp=0", cyc, obs);
      end
    end
    reset_p = 1'b1;
    repeat (4) begin
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_clean_press();
    int k, fall_k;
    int pe_at = -1, ne_at = -1, longs = 0;
    k = cyc;
    bus.btn_raw[0] = 1'b1;
    repeat (10) begin
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (bus.btn_pe[0]) pe_at = cyc;
      if (bus.btn_long[0]) longs++;
    end
    fall_k = cyc;
    bus.btn_raw[0] = 1'b0;
    repeat (12) begin
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL clean_release cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (bus.btn_ne[0]) ne_at = cyc;
      if (bus.btn_long[0]) longs++;
    end
    n_cmp++;
    if (pe_at - k !== D + 2) begin
      n_bad++; $display("FAIL press_latency got=%0d exp=%0d", pe_at - k, D + 2);
    end
    n_cmp++;
    if (ne_at - fall_k !== D + 2) begin
      n_bad++; $display("FAIL release_latency got=%0d exp=%0d", ne_at - fall_k, D + 2);
    end
    n_cmp++;
    if (longs !== 0) begin
      n_bad++; $display("FAIL short_press_long got=%0d exp=0", longs);
    end
  endtask

  task automatic test_glitch();
    bit q[$];
    int stable_idx;
    int k = 0, pe_cnt = 0, pe_at = -1, early_lvl = 0;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, D - 1)) q.push_back(1'b1);
      repeat ($urandom_range(1, 3)) q.push_back(1'b0);
    end
    stable_idx = q.size();
    repeat (D) q.push_back(1'b1);
    repeat (14) q.push_back(1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (i == stable_idx) k = cyc;
      bus.btn_raw[1] = q[i];
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (bus.btn_pe[1]) begin pe_cnt++; pe_at = cyc; end
      if (i < stable_idx && bus.btn_level[1]) early_lvl++;
    end
    n_cmp++;
    if (early_lvl !== 0) begin
      n_bad++; $display("FAIL glitch_level got=%0d exp=0", early_lvl);
    end
    n_cmp++;
    if (pe_cnt !== 1) begin
      n_bad++; $display("FAIL glitch_pe_count got=%0d exp=1", pe_cnt);
    end
    n_cmp++;
    if (pe_at - k !== D + 2) begin
      n_bad++; $display("FAIL glitch_pe_latency got=%0d exp=%0d", pe_at - k, D + 2);
    end
  endtask

  task automatic test_hold(input int ch);
    int pe_at = -1, long_at = -1, long_cnt = 0;
    int rpt_seen[$];
    int rpt_exp[$];
    rpt_exp.push_back(0);
    if (MASK[ch]) for (int o = L; o < 40; o += R) rpt_exp.push_back(o);
    bus.btn_raw[ch] = 1'b1;
    for (int i = 0; i < 52; i++) begin
      if (i == 40) bus.btn_raw[ch] = 1'b0;
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL hold_ch%0d cyc=%0d got=%b exp=%b", ch, cyc, obs, expv);
      end
      if (bus.btn_pe[ch]) pe_at = cyc;
      if (bus.btn_long[ch]) begin long_cnt++; long_at = cyc; end
      if (bus.btn_rpt[ch]) rpt_seen.push_back(cyc);
    end
    n_cmp++;
    if (long_cnt !== 1 || long_at - pe_at !== L) begin
      n_bad++; $display("FAIL hold_long_ch%0d got=%0d@%0d exp=1@%0d", ch, long_cnt, long_at - pe_at, L);
    end
    n_cmp++;
    if (rpt_seen.size() !== rpt_exp.size()) begin
      n_bad++; $display("FAIL hold_rpt_count_ch%0d got=%0d exp=%0d", ch, rpt_seen.size(), rpt_exp.size());
    end else begin
      for (int i = 0; i < rpt_exp.size(); i++) begin
        n_cmp++;
        if (rpt_seen[i] - pe_at !== rpt_exp[i]) begin
          n_bad++; $display("FAIL hold_rpt_ofs_ch%0d got=%0d exp=%0d", ch, rpt_seen[i] - pe_at, rpt_exp[i]);
        end
      end
    end
  endtask

  task automatic test_release_at_long();
    int pe_at = -1, ne_at = -1, long_cnt = 0, rpt_cnt = 0;
    bus.btn_raw[3] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == L) bus.btn_raw[3] = 1'b0;
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL release_long cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (bus.btn_pe[3]) pe_at = cyc;
      if (bus.btn_ne[3]) ne_at = cyc;
      if (bus.btn_long[3]) long_cnt++;
      if (bus.btn_rpt[3]) rpt_cnt++;
    end
    n_cmp++;
    if (ne_at - pe_at !== L) begin
      n_bad++; $display("FAIL release_long_ne got=%0d exp=%0d", ne_at - pe_at, L);
    end
    n_cmp++;
    if (long_cnt !== 0 || rpt_cnt !== 1) begin
      n_bad++; $display("FAIL release_long_prio got=long%0d/rpt%0d exp=long0/rpt1", long_cnt, rpt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int k, pe_at = -1;
    bus.btn_raw[2] = 1'b1;
    repeat (D + 12) begin
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL reset_mid_hold cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    reset_p = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_async got=%b exp=0", obs);
    end
    repeat (3) begin
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL reset_mid_held cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    reset_p = 1'b1;
    k = cyc;
    for (int i = 0; i < 22; i++) begin
      if (i == 12) bus.btn_raw[2] = 1'b0;
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (bus.btn_pe[2] && pe_at < 0) pe_at = cyc;
    end
    n_cmp++;
    if (pe_at - k !== D + 2) begin
      n_bad++; $display("FAIL reset_repress_latency got=%0d exp=%0d", pe_at - k, D + 2);
    end
  endtask

  task automatic test_random();
    int rem [N];
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int i = 0; i < 1515; i++) begin
      for (int c = 0; c < N; c++) begin
        if (i >= 1500) begin
          bus.btn_raw[c] = 1'b0;
        end else begin
          if (rem[c] == 0) begin
            bus.btn_raw[c] = ~bus.btn_raw[c];
            rem[c] = bus.btn_raw[c] ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 15));
          end
          rem[c]--;
        end
      end
      if (i == 700) reset_p = 1'b0;
      if (i == 703) reset_p = 1'b1;
      tick();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold(3);
    test_hold(0);
    test_release_at_long();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
